// File: rtl/regmap_spi_initiator.sv
`timescale 1ns/1ps
// SPI mode-0 target that turns one host frame into one register-map access.
// All SPI pins are oversampled in clk_i; a frame is R/W, address, then data
// (write) or read data returned on MISO.
module regmap_spi_initiator #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter int WR_HOLD    = 4,
  parameter int WR_GAP     = 4,
  parameter int RD_LAT     = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  sclk_i,
  input  logic                  cs_n_i,
  input  logic                  mosi_i,
  output logic                  miso_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [DATA_WIDTH-1:0] write_data_o,
  output logic                  write_en_o,
  output logic                  read_en_o,
  input  logic [DATA_WIDTH-1:0] read_data_i,
  output logic                  busy_o,
  output logic                  frame_err_o
);

  localparam int FW   = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int BW   = $clog2(FW + 1);
  localparam int SW   = (ADDR_WIDTH + 1 > DATA_WIDTH) ? ADDR_WIDTH + 1 : DATA_WIDTH;
  localparam int TMAX = (WR_HOLD > WR_GAP) ? ((WR_HOLD > RD_LAT) ? WR_HOLD : RD_LAT)
                                           : ((WR_GAP > RD_LAT) ? WR_GAP : RD_LAT);
  localparam int CW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_RD_REQ, S_RD_OUT, S_WR_DATA, S_WR_PULSE, S_WR_GAP, S_DONE
  } state_t;

  // Pin order in the synchroniser bank: 0 = sclk, 1 = cs_n, 2 = mosi.
  // cs_n idles high, so its flops come out of reset as 1.
  localparam logic [2:0] SYNC_RST = 3'b010;

  logic [2:0] pin_raw;
  logic [2:0] pin_sync;
  assign pin_raw = {mosi_i, cs_n_i, sclk_i};

  genvar gi;
  for (gi = 0; gi < 3; gi++) begin : g_sync
    logic meta_q;
    logic stab_q;
    // Two-flop synchroniser for one asynchronous SPI pin
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        meta_q <= SYNC_RST[gi];
        stab_q <= SYNC_RST[gi];
      end else begin
        meta_q <= pin_raw[gi];
        stab_q <= meta_q;
      end
    end
    assign pin_sync[gi] = stab_q;
  end

  logic sclk_s, cs_s, mosi_s;
  assign sclk_s = pin_sync[0];
  assign cs_s   = pin_sync[1];
  assign mosi_s = pin_sync[2];

  logic sclk_dly_q, cs_dly_q;
  // Delayed copies of the synced sclk / cs_n for edge detection
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sclk_dly_q <= 1'b0;
      cs_dly_q   <= 1'b1;
    end else begin
      sclk_dly_q <= sclk_s;
      cs_dly_q   <= cs_s;
    end
  end

  logic sclk_rise, sclk_fall, cs_fall;
  assign sclk_rise = sclk_s & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s & sclk_dly_q;
  assign cs_fall   = ~cs_s & cs_dly_q;

  state_t                state_q, state_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [SW-2:0]         sh_q, sh_d;
  logic [SW-1:0]         sh_next;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  abort_q, abort_d;
  logic                  ferr_q, ferr_d;
  logic                  miso_q, miso_d;
  logic                  wen_q, wen_d;
  logic                  ren_q, ren_d;
  logic                  busy_q, busy_d;
  logic                  abort_now;

  // The shifter keeps the previous bits; sh_next is the word including this bit.
  assign sh_next   = {sh_q, mosi_s};
  // cs_n already seen high during an unfinishable bus sequence
  assign abort_now = abort_q | cs_s;

  // Frame sequencing: next state, datapath captures and registered strobes
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    abort_d   = abort_q;
    ferr_d    = ferr_q;
    miso_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          bit_cnt_d = '0;
          ferr_d    = 1'b0;
          abort_d   = 1'b0;
          state_d   = S_CMD;
        end
      end
      S_CMD: begin
        if (cs_s) begin
          ferr_d  = 1'b1;
          state_d = S_IDLE;
        end else if (sclk_rise) begin
          sh_d      = sh_next[SW-2:0];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BW'(ADDR_WIDTH)) begin
            addr_d  = sh_next[ADDR_WIDTH-1:0];
            cnt_d   = '0;
            state_d = sh_next[ADDR_WIDTH] ? S_WR_DATA : S_RD_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (cs_s) begin
          ferr_d  = 1'b1;
          abort_d = 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(RD_LAT - 1)) begin
          tx_d    = read_data_i;
          state_d = abort_now ? S_IDLE : S_RD_OUT;
        end
      end
      S_RD_OUT: begin
        miso_d = miso_q;
        if (cs_s) begin
          ferr_d  = 1'b1;
          miso_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          if (sclk_fall) begin
            miso_d = tx_q[DATA_WIDTH-1];
            tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
          end
          if (sclk_rise) begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == BW'(FW - 1)) begin
              miso_d  = 1'b0;
              state_d = S_DONE;
            end
          end
        end
      end
      S_WR_DATA: begin
        if (cs_s) begin
          ferr_d  = 1'b1;
          state_d = S_IDLE;
        end else if (sclk_rise) begin
          sh_d      = sh_next[SW-2:0];
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BW'(FW - 1)) begin
            wdata_d = sh_next[DATA_WIDTH-1:0];
            cnt_d   = '0;
            state_d = S_WR_PULSE;
          end
        end
      end
      S_WR_PULSE: begin
        if (cs_s) begin
          ferr_d  = 1'b1;
          abort_d = 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WR_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = S_WR_GAP;
        end
      end
      S_WR_GAP: begin
        if (cs_s) begin
          ferr_d  = 1'b1;
          abort_d = 1'b1;
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WR_GAP - 1)) begin
          state_d = abort_now ? S_IDLE : S_DONE;
        end
      end
      S_DONE: begin
        if (cs_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Strobes are registered and line up exactly with the state they belong to
    wen_d  = (state_d == S_WR_PULSE);
    ren_d  = (state_d == S_RD_REQ);
    busy_d = wen_d | ren_d | (state_d == S_WR_GAP);
  end

  // State and datapath registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      cnt_q     <= '0;
      sh_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      abort_q   <= 1'b0;
      ferr_q    <= 1'b0;
      miso_q    <= 1'b0;
      wen_q     <= 1'b0;
      ren_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      abort_q   <= abort_d;
      ferr_q    <= ferr_d;
      miso_q    <= miso_d;
      wen_q     <= wen_d;
      ren_q     <= ren_d;
      busy_q    <= busy_d;
    end
  end

  assign miso_o       = miso_q;
  assign addr_o       = addr_q;
  assign write_data_o = wdata_q;
  assign write_en_o   = wen_q;
  assign read_en_o    = ren_q;
  assign busy_o       = busy_q;
  assign frame_err_o  = ferr_q;

endmodule

// File: tb/tb_regmap_spi_initiator.sv
`timescale 1ns/1ps
// Bench for regmap_spi_initiator: a bit-banged SPI host, a register-map read
// model and a scoreboard of expected bus accesses and MISO read data.
module tb_regmap_spi_initiator;

  localparam int AW      = 7;
  localparam int DW      = 8;
  localparam int HOLD    = 4;
  localparam int GAP     = 4;
  localparam int LAT     = 3;
  localparam int HALF    = 10;

  logic          clk;
  logic          rst_i;
  logic          sclk, cs_n, mosi;
  logic          miso_o;
  logic [AW-1:0] addr_o;
  logic [DW-1:0] write_data_o;
  logic          write_en_o, read_en_o, busy_o, frame_err_o;
  logic [DW-1:0] rd_data;

  regmap_spi_initiator #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WR_HOLD(HOLD), .WR_GAP(GAP), .RD_LAT(LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .sclk_i(sclk), .cs_n_i(cs_n), .mosi_i(mosi),
    .miso_o(miso_o), .addr_o(addr_o), .write_data_o(write_data_o),
    .write_en_o(write_en_o), .read_en_o(read_en_o), .read_data_i(rd_data),
    .busy_o(busy_o), .frame_err_o(frame_err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } bus_exp_t;

  bus_exp_t      exp_q[$];
  logic [DW-1:0] rd_q[$];

  int            n_tests = 0;
  int            n_fail  = 0;

  // monitor / model state
  logic          we_prev = 1'b0, re_prev = 1'b0, busy_prev = 1'b0;
  int            we_cnt = 0, re_cnt = 0, busy_cnt = 0, rd_age = 0;
  bit            mon_en = 1'b1, gap_active = 1'b0, last_wr = 1'b0;
  logic [AW-1:0] hold_addr = '0;
  logic [DW-1:0] hold_data = '0;
  logic [DW-1:0] rd_val = '0;
  logic [15:0]   mb;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock step: advance to the falling edge, then run the register-map
  // model and the bus monitor on the settled outputs.
  task automatic tick();
    bus_exp_t e;
    @(negedge clk);
    if (read_en_o) rd_age++; else rd_age = 0;
    rd_data = (rd_age >= 3) ? rd_val : '0;

    if (gap_active && busy_o) begin
      check("gap_addr", addr_o, hold_addr);
      check("gap_data", write_data_o, hold_data);
    end
    if (write_en_o && !we_prev) begin
      if (exp_q.size() == 0) check("unexp_write", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("wr_kind", e.is_wr, 1);
        check("wr_addr", addr_o, e.addr);
        check("wr_data", write_data_o, e.data);
      end
      we_cnt  = 0;
      last_wr = 1'b1;
    end
    if (write_en_o) we_cnt++;
    if (!write_en_o && we_prev && mon_en) begin
      check("we_len", we_cnt, HOLD);
      hold_addr  = addr_o;
      hold_data  = write_data_o;
      gap_active = 1'b1;
    end
    if (read_en_o && !re_prev) begin
      if (exp_q.size() == 0) check("unexp_read", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("rd_kind", e.is_wr, 0);
        check("rd_addr", addr_o, e.addr);
      end
      re_cnt  = 0;
      last_wr = 1'b0;
    end
    if (read_en_o) re_cnt++;
    if (!read_en_o && re_prev && mon_en) check("re_len", re_cnt, LAT);
    if (busy_o && !busy_prev) busy_cnt = 0;
    if (busy_o) busy_cnt++;
    if (!busy_o && busy_prev) begin
      if (mon_en) check("busy_len", busy_cnt, last_wr ? HOLD + GAP : LAT);
      gap_active = 1'b0;
    end
    we_prev   = write_en_o;
    re_prev   = read_en_o;
    busy_prev = busy_o;
  endtask

  task automatic tickn(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  function automatic logic [15:0] wr_frame(input logic [AW-1:0] a, input logic [DW-1:0] d);
    return {1'b1, a, d};
  endfunction

  function automatic logic [15:0] rd_frame(input logic [AW-1:0] a);
    return {1'b0, a, 8'h00};
  endfunction

  // Drive nbits of a frame MSB first; MISO is sampled just before each rise.
  // With hold_last the task returns with SCLK still high after the last bit.
  task automatic spi_xfer(input logic [15:0] frame, input int nbits, input bit hold_last,
                          output logic [15:0] miso_bits);
    miso_bits = '0;
    sclk = 1'b0;
    cs_n = 1'b0;
    tickn(HALF);
    for (int i = 0; i < nbits; i++) begin
      mosi = frame[15-i];
      tickn(HALF);
      miso_bits = {miso_bits[14:0], miso_o};
      sclk = 1'b1;
      if (!(hold_last && i == nbits - 1)) begin
        tickn(HALF);
        sclk = 1'b0;
      end
    end
  endtask

  task automatic cs_end();
    tickn(HALF);
    cs_n = 1'b1;
    mosi = 1'b0;
    tickn(2 * HALF);
  endtask

  task automatic wait_we();
    for (int i = 0; i < 40 && !write_en_o; i++) tick();
    check("we_seen", write_en_o, 1);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_q.push_back('{is_wr: 1'b1, addr: a, data: d});
    spi_xfer(wr_frame(a, d), 16, 1'b0, mb);
    check("ferr_wr", frame_err_o, 0);
    cs_end();
    $display("[TB] write addr=0x%02h data=0x%02h", a, d);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] v);
    logic [DW-1:0] e;
    rd_val = v;
    exp_q.push_back('{is_wr: 1'b0, addr: a, data: '0});
    rd_q.push_back(v);
    spi_xfer(rd_frame(a), 16, 1'b0, mb);
    cs_end();
    check("miso_cmd", mb[15:8], 0);
    e = rd_q.pop_front();
    check("miso_data", mb[7:0], e);
    check("ferr_rd", frame_err_o, 0);
    $display("[TB] read  addr=0x%02h miso=0x%02h", a, mb[7:0]);
  endtask

  initial begin
    rst_i = 1'b1;
    sclk  = 1'b0;
    cs_n  = 1'b1;
    mosi  = 1'b0;
    rd_data = '0;
    tickn(3);
    check("rst_addr", addr_o, 0);
    check("rst_wdata", write_data_o, 0);
    check("rst_we", write_en_o, 0);
    check("rst_re", read_en_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_miso", miso_o, 0);
    check("rst_ferr", frame_err_o, 0);
    rst_i = 1'b0;
    tickn(3);

    // plain write, then values hold in IDLE
    do_write(7'h03, 8'hA5);
    check("idle_addr", addr_o, 7'h03);
    check("idle_wdata", write_data_o, 8'hA5);

    // reads
    do_read(7'h03, 8'h5A);
    do_read(7'h7F, 8'hFF);

    // cs_n raised after 5 command bits, then a clean frame
    spi_xfer(wr_frame(7'h03, 8'h00), 5, 1'b0, mb);
    cs_end();
    check("ferr_cmd_abort", frame_err_o, 1);
    $display("[TB] abort after 5 cmd bits ferr=%0d", frame_err_o);
    do_write(7'h0A, 8'h3C);
    check("ferr_after_clean", frame_err_o, 0);

    // cs_n raised 2 cycles into the write pulse
    exp_q.push_back('{is_wr: 1'b1, addr: 7'h22, data: 8'h99});
    spi_xfer(wr_frame(7'h22, 8'h99), 16, 1'b1, mb);
    wait_we();
    tickn(2);
    cs_n = 1'b1;
    tickn(4);
    sclk = 1'b0;
    mosi = 1'b0;
    tickn(3 * HALF);
    check("ferr_pulse_abort", frame_err_o, 1);
    check("addr_pulse_abort", addr_o, 7'h22);
    check("busy_pulse_abort", busy_o, 0);
    $display("[TB] abort in write pulse ferr=%0d", frame_err_o);

    // asynchronous reset in the middle of the write pulse
    exp_q.push_back('{is_wr: 1'b1, addr: 7'h11, data: 8'h3C});
    spi_xfer(wr_frame(7'h11, 8'h3C), 16, 1'b1, mb);
    wait_we();
    #2;
    mon_en = 1'b0;
    rst_i  = 1'b1;
    cs_n   = 1'b1;
    sclk   = 1'b0;
    mosi   = 1'b0;
    #1;
    check("arst_we", write_en_o, 0);
    check("arst_re", read_en_o, 0);
    check("arst_busy", busy_o, 0);
    check("arst_miso", miso_o, 0);
    tickn(3);
    rst_i = 1'b0;
    tickn(5);
    mon_en = 1'b1;
    check("post_rst_busy", busy_o, 0);
    check("post_rst_ferr", frame_err_o, 0);
    $display("[TB] reset mid write pulse we=%0d busy=%0d", write_en_o, busy_o);

    do_write(7'h05, 8'h0F);
    check("post_rst_addr", addr_o, 7'h05);

    tickn(20);
    check("exp_q_empty", exp_q.size(), 0);
    check("rd_q_empty", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regmap_spi_initiator.md
Name: regmap_spi_initiator

Overview:
- SPI mode-0 target front end that acts as the bus initiator for the configuration/status register map.
- Deserialises host SPI frames, then drives the register map's addr / write_data / write_en / read_en port set. For reads it captures read data and shifts it back on MISO.
- Sits between chip pads and the register map, entirely in the clk_i domain; SPI pins are oversampled.

Parameters:
ADDR_WIDTH, 7, register address width (frame: 1 R/W bit + ADDR_WIDTH addr bits + DATA_WIDTH data bits)
DATA_WIDTH, 8, register data width
WR_HOLD, 4, clk_i cycles write_en_o is held high (min 3)
WR_GAP, 4, clk_i cycles addr/data held after write_en_o falls (min 4)
RD_LAT, 3, clk_i cycles read_en_o is held before read_data_i is captured (min 3)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
sclk_i  in  1  SPI clock, asynchronous
cs_n_i  in  1  SPI chip select, active low, asynchronous
mosi_i  in  1  SPI data in, asynchronous
miso_o  out  1  SPI data out
addr_o  out  ADDR_WIDTH  register address
write_data_o  out  DATA_WIDTH  write data
write_en_o  out  1  write strobe (level, register map edge-detects it)
read_en_o  out  1  read enable
read_data_i  in  DATA_WIDTH  register read data
busy_o  out  1  bus transaction in progress
frame_err_o  out  1  sticky: cs_n rose mid-frame; cleared by next cs_n fall

Behaviour:
- Reset is asynchronous and active-high. Reset values: all outputs 0, miso_o 0, FSM IDLE, bit counter 0, sync flops 0 (cs_n sync flops 1).
- Synchronisation:
  - sclk_i, cs_n_i and mosi_i each pass through a 2-flop synchroniser.
  - sclk edges are detected from sync stage 2 vs a delayed copy.
  - mosi is sampled on the detected rising edge.
  - miso_o updates on the detected falling edge.
  - Constraint: SCLK high and low phases are each >= 8 clk_i cycles.
- Frame, MSB first:
  - bit 0 = R/W (1 = write);
  - bits 1..ADDR_WIDTH = address;
  - next DATA_WIDTH bits = data (write) or MISO read data (read).
- FSM states: IDLE, CMD, RD_REQ, RD_OUT, WR_DATA, WR_PULSE, WR_GAP, DONE.
  - IDLE -> CMD on synced cs_n falling; clears bit counter and frame_err_o.
  - CMD shifts 1+ADDR_WIDTH bits, then latches addr_o.
    - If R/W=1 -> WR_DATA.
    - If R/W=0 -> RD_REQ.
  - RD_REQ: read_en_o=1 for RD_LAT cycles with addr_o stable; capture read_data_i on the last cycle into the tx shift register; read_en_o drops; -> RD_OUT.
    - Latency from the address-LSB rising edge to capture is RD_LAT+1 cycles, which is below one SCLK half period.
  - RD_OUT: data MSB is driven on the first SCLK falling edge after capture. The remaining bits are driven on subsequent falling edges. After DATA_WIDTH rising edges -> DONE.
  - WR_DATA: shift DATA_WIDTH bits, latch write_data_o, -> WR_PULSE.
  - WR_PULSE: write_en_o=1 for WR_HOLD cycles -> WR_GAP.
  - WR_GAP: write_en_o=0 for WR_GAP cycles -> DONE.
    - addr_o and write_data_o stay unchanged from WR_PULSE entry until the end of WR_GAP.
  - DONE: waits for synced cs_n high -> IDLE. Extra SCLK edges are ignored and miso_o is held 0.
- busy_o = 1 in RD_REQ, WR_PULSE and WR_GAP.
- addr_o and write_data_o hold their last values in IDLE. They are not cleared.
- cs_n rising before the frame completes:
  - in CMD, WR_DATA or RD_OUT: frame_err_o=1, no bus access, -> IDLE.
  - in RD_REQ, WR_PULSE or WR_GAP: the bus sequence runs to completion (no truncated write_en pulse), frame_err_o=1, then -> IDLE.
- cs_n falling while busy (after an abort) is ignored until the FSM reaches IDLE.
- Reset asserted mid-transaction forces write_en_o and read_en_o to 0 immediately.
- One access per cs_n assertion. No auto-increment.

Test Plan:
- Write frame 1_0000011_0xA5 with SCLK period 20 clk -> addr_o=0x03, write_data_o=0xA5, write_en_o high exactly 4 cycles then low 4 cycles with addr/data stable; busy_o high 8 cycles; frame_err_o=0.
- Read frame 0_0000011 with a register-map model returning 0x5A two cycles after read_en -> read_en_o high 3 cycles; MISO bits on the next 8 SCLK rises = 0,1,0,1,1,0,1,0.
- Read of addr 0x7F with the model returning 0xFF -> MISO 0xFF; write_en_o never asserted.
- cs_n raised after 5 CMD bits -> frame_err_o=1, no read_en/write_en activity; next clean write frame succeeds and clears frame_err_o at cs_n fall.
- cs_n raised 2 cycles into WR_PULSE -> write_en_o still high 4 full cycles and WR_GAP completes; frame_err_o=1.
- rst_i asserted mid-WR_PULSE without a clock edge -> write_en_o=0, busy_o=0, miso_o=0 combinationally; FSM in IDLE after release.
